// File: rtl/imem_loader_if.sv
// Bundle between the instruction-memory loader, its serial byte source,
// the instruction-memory write port and the CPU front-end status lines.
interface imem_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        hold;
    logic        done;
    logic        err;

    modport master (
        output start, in_valid, in_byte,
        input  in_ready, we, waddr, wdata, hold, done, err
    );

    modport slave (
        input  start, in_valid, in_byte,
        output in_ready, we, waddr, wdata, hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Serial instruction-memory loader: count byte, big-endian words, XOR checksum,
// keeps the CPU front end held until a clean load completes.
module imem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, COUNT, ASSEMBLE, WRITE, CHECK, FIN} state_t;

    state_t      state, state_nx;
    logic [7:0]  waddr, waddr_nx;
    logic [31:0] wdata, wdata_nx;
    logic [7:0]  csum, csum_nx;
    logic [6:0]  words, words_nx;
    logic [1:0]  byte_cnt, byte_cnt_nx;
    logic        hold, hold_nx;
    logic        done, done_nx;
    logic        err, err_nx;
    logic        accept;

    assign bus.in_ready = (state == COUNT) || (state == ASSEMBLE) || (state == CHECK);
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.we       = (state == WRITE);
    assign bus.waddr    = waddr;
    assign bus.wdata    = wdata;
    assign bus.hold     = hold;
    assign bus.done     = done;
    assign bus.err      = err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            waddr    <= BASE_ADDR;
            wdata    <= 32'h0;
            csum     <= 8'h0;
            words    <= 7'd0;
            byte_cnt <= 2'd0;
            hold     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            waddr    <= waddr_nx;
            wdata    <= wdata_nx;
            csum     <= csum_nx;
            words    <= words_nx;
            byte_cnt <= byte_cnt_nx;
            hold     <= hold_nx;
            done     <= done_nx;
            err      <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        waddr_nx    = waddr;
        wdata_nx    = wdata;
        csum_nx     = csum;
        words_nx    = words;
        byte_cnt_nx = byte_cnt;
        hold_nx     = hold;
        done_nx     = done;
        err_nx      = err;
        case (state)
            IDLE, FIN: begin
                if (bus.start) begin
                    state_nx    = COUNT;
                    hold_nx     = 1'b1;
                    done_nx     = 1'b0;
                    err_nx      = 1'b0;
                    waddr_nx    = BASE_ADDR;
                    csum_nx     = 8'h0;
                    byte_cnt_nx = 2'd0;
                end
            end
            COUNT: begin
                if (accept) begin
                    if (bus.in_byte > 8'd64) begin
                        state_nx = FIN;
                        done_nx  = 1'b1;
                        err_nx   = 1'b1;
                        hold_nx  = 1'b1;
                    end else begin
                        // A zero count means the full 64-word image.
                        words_nx    = (bus.in_byte == 8'd0) ? 7'd64 : bus.in_byte[6:0];
                        byte_cnt_nx = 2'd0;
                        state_nx    = ASSEMBLE;
                    end
                end
            end
            ASSEMBLE: begin
                if (accept) begin
                    wdata_nx    = {wdata[23:0], bus.in_byte};
                    csum_nx     = csum ^ bus.in_byte;
                    byte_cnt_nx = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3)
                        state_nx = WRITE;
                end
            end
            WRITE: begin
                waddr_nx = waddr + 8'd4;
                words_nx = words - 7'd1;
                state_nx = (words == 7'd1) ? CHECK : ASSEMBLE;
            end
            CHECK: begin
                if (accept) begin
                    state_nx = FIN;
                    done_nx  = 1'b1;
                    err_nx   = (bus.in_byte != csum);
                    hold_nx  = (bus.in_byte != csum);
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scenario-driven bench for imem_loader with a write scoreboard.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst;

    imem_loader_if ifc ();

    imem_loader #(.BASE_ADDR(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    bit chk_rdy  = 1'b0;
    logic [39:0] sb[$];

    always @(negedge clk) begin
        if (rst === 1'b1 && ifc.we === 1'b1) begin
            logic [39:0] exp;
            we_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_we: addr=%02h data=%08h, required no write", ifc.waddr, ifc.wdata);
            end else begin
                exp = sb.pop_front();
                if ({ifc.waddr, ifc.wdata} !== exp) begin
                    failures++;
                    $display("FAIL write: got %02h/%08h, required %02h/%08h",
                             ifc.waddr, ifc.wdata, exp[39:32], exp[31:0]);
                end
            end
        end
        if (chk_rdy) begin
            checks++;
            if (ifc.in_ready !== ~ifc.we) begin
                failures++;
                $display("FAIL ready_vs_write: in_ready=%b we=%b, required in_ready=~we", ifc.in_ready, ifc.we);
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        checks++;
        if ({ifc.hold, ifc.done, ifc.err, ifc.waddr} !== {3'b100, 8'h00}) begin
            failures++;
            $display("FAIL start_state: hold/done/err/waddr=%b%b%b/%02h, required 100/00",
                     ifc.hold, ifc.done, ifc.err, ifc.waddr);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        bit rdy;
        int budget;
        int gaps;
        gaps = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
        repeat (gaps) begin
            @(posedge clk); #1;
        end
        ifc.in_valid = 1'b1;
        ifc.in_byte  = b;
        budget = 0;
        do begin
            @(negedge clk);
            rdy = ifc.in_ready;
            @(posedge clk); #1;
            budget++;
        end while (!rdy && budget < 50);
        ifc.in_valid = 1'b0;
        ifc.in_byte  = 8'($urandom);
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout: byte %02h not accepted, required acceptance", b);
        end
    endtask

    task automatic send_word(input logic [7:0] addr, input logic [31:0] w,
                             input int gapmax, inout logic [7:0] sum);
        sb.push_back({addr, w});
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8], gapmax);
            sum = sum ^ w[8*i +: 8];
        end
    endtask

    task automatic check_end(input string name, input logic exp_err, input int exp_we, input int we0);
        int budget = 0;
        while (ifc.done !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        checks++;
        if ({ifc.done, ifc.err, ifc.hold} !== {1'b1, exp_err, exp_err}) begin
            failures++;
            $display("FAIL %s_status: done/err/hold=%b%b%b, required 1%b%b",
                     name, ifc.done, ifc.err, ifc.hold, exp_err, exp_err);
        end
        checks++;
        if ((we_cnt - we0) != exp_we || sb.size() != 0) begin
            failures++;
            $display("FAIL %s_writes: %0d strobes, %0d pending, required %0d strobes, 0 pending",
                     name, we_cnt - we0, sb.size(), exp_we);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifc.start = 1'b0; ifc.in_valid = 1'b0; ifc.in_byte = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifc.in_ready, ifc.we, ifc.waddr, ifc.wdata, ifc.hold, ifc.done, ifc.err}
            !== {2'b00, 8'h00, 32'h0, 3'b100}) begin
            failures++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%02h data=%08h hold=%b done=%b err=%b",
                     ifc.in_ready, ifc.we, ifc.waddr, ifc.wdata, ifc.hold, ifc.done, ifc.err);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        int we0 = we_cnt;
        do_start();
        send_byte(8'h01, 0);
        sb.push_back({8'h00, 32'h12345678});
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'h56, 0); send_byte(8'h78, 0);
        send_byte(8'h08, 0);
        check_end("single", 1'b0, 1, we0);
    endtask

    task automatic test_gaps();
        int we0 = we_cnt;
        logic [7:0] sum = 8'h00;
        do_start();
        chk_rdy = 1'b1;
        send_byte(8'h02, 3);
        send_word(8'h00, $urandom, 3, sum);
        send_word(8'h04, $urandom, 3, sum);
        send_byte(sum, 3);
        chk_rdy = 1'b0;
        check_end("gaps", 1'b0, 2, we0);
    endtask

    task automatic test_bad_checksum();
        int we0 = we_cnt;
        do_start();
        send_byte(8'h01, 0);
        sb.push_back({8'h00, 32'h12345678});
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'h56, 0); send_byte(8'h78, 0);
        send_byte(8'hFF, 0);
        check_end("badsum", 1'b1, 1, we0);
    endtask

    task automatic test_full_image();
        int we0 = we_cnt;
        logic [7:0] sum = 8'h00;
        do_start();
        send_byte(8'h00, 0);
        for (int i = 0; i < 64; i++)
            send_word(8'(i * 4), $urandom, 0, sum);
        send_byte(sum, 0);
        check_end("full", 1'b0, 64, we0);
        checks++;
        if (ifc.waddr !== 8'h00) begin
            failures++;
            $display("FAIL full_wrap: waddr=%02h, required 00", ifc.waddr);
        end
    endtask

    task automatic test_bad_count();
        int we0 = we_cnt;
        do_start();
        send_byte(8'h41, 0);
        check_end("badcount", 1'b1, 0, we0);
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL badcount_ready: in_ready=%b, required 0", ifc.in_ready);
        end
    endtask

    task automatic test_start_ignored();
        int we0 = we_cnt;
        do_start();
        send_byte(8'h01, 0);
        sb.push_back({8'h00, 32'hA5C3_0F96});
        send_byte(8'hA5, 0); send_byte(8'hC3, 0);
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        send_byte(8'h0F, 0); send_byte(8'h96, 0);
        send_byte(8'hA5 ^ 8'hC3 ^ 8'h0F ^ 8'h96, 0);
        check_end("startign", 1'b0, 1, we0);
    endtask

    task automatic test_reset_midload();
        int we0;
        logic [7:0] sum = 8'h00;
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({ifc.in_ready, ifc.we, ifc.waddr, ifc.wdata, ifc.hold, ifc.done, ifc.err}
            !== {2'b00, 8'h00, 32'h0, 3'b100}) begin
            failures++;
            $display("FAIL midload_reset: rdy=%b we=%b addr=%02h data=%08h hold=%b done=%b err=%b",
                     ifc.in_ready, ifc.we, ifc.waddr, ifc.wdata, ifc.hold, ifc.done, ifc.err);
        end
        @(negedge clk);
        rst = 1'b1;
        we0 = we_cnt;
        do_start();
        send_byte(8'h01, 0);
        send_word(8'h00, 32'hDEADBEEF, 0, sum);
        send_byte(sum, 0);
        check_end("afterreset", 1'b0, 1, we0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gaps();
        test_bad_checksum();
        test_full_image();
        test_bad_count();
        test_start_ignored();
        test_reset_midload();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00, byte address at which the first loaded word is written.
REQ-002 SHALL have ports as follows; one clock; reset is asynchronous and active-low.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle request to begin a load.
- IN_VALID  input  1  IN_BYTE holds a valid byte.
- IN_BYTE  input  8  serial load stream byte.
- IN_READY  output  1  loader can accept a byte this cycle.
- WE  output  1  instruction-memory write strobe.
- WADDR  output  8  byte address of the word being written.
- WDATA  output  32  instruction word being written.
- HOLD  output  1  keeps the CPU front end stalled (drives IF LE low and pipeline in reset).
- DONE  output  1  load finished.
- ERR  output  1  load finished with an error.

Function
REQ-003 SHALL implement states IDLE, COUNT, ASSEMBLE, WRITE, CHECK and FIN.
REQ-004 SHALL accept a byte only on a rising edge where IN_VALID=1 and IN_READY=1.
REQ-005 SHALL drive IN_READY=1 only in COUNT, ASSEMBLE and CHECK.
REQ-006 IDLE or FIN with START=1 SHALL go to COUNT, set HOLD=1, DONE=0 and ERR=0, load WADDR=BASE_ADDR, and clear the checksum accumulator.
REQ-007 START SHALL be ignored in COUNT, ASSEMBLE, WRITE and CHECK.
REQ-008 In COUNT, the accepted byte is the word count: 1..64 = that many words; 0 = 64 words; greater than 64 = error, go to FIN with ERR=1 and no writes.
REQ-009 ASSEMBLE SHALL collect 4 accepted bytes big-endian (first byte to WDATA[31:24]) and XOR each byte into an 8-bit checksum accumulator; the count byte SHALL be excluded from the checksum.
REQ-010 When the 4th byte is accepted at edge k, the block SHALL be in WRITE for exactly the cycle after edge k, with WE=1 and WADDR/WDATA stable.
REQ-011 WE SHALL be 0 in every other state.
REQ-012 On leaving WRITE, WADDR SHALL add 4 modulo 256 (wrap-around permitted), and the remaining word count SHALL decrement.
REQ-013 After WRITE, the block SHALL go to ASSEMBLE if words remain, otherwise to CHECK.
REQ-014 CHECK SHALL accept one checksum byte, then go to FIN with ERR=1 if it differs from the accumulator, ERR=0 otherwise.
REQ-015 Writes already performed SHALL NOT be undone on a checksum error.
REQ-016 In FIN: DONE=1, HOLD=0 if ERR=0, HOLD=1 if ERR=1; outputs SHALL hold until the next START.
REQ-017 Gaps in IN_VALID SHALL stall the FSM in its state with no loss or duplication of bytes.
REQ-018 A partial word SHALL be retained across gaps.

Reset
REQ-019 RST=0 SHALL immediately force IDLE with IN_READY=0, WE=0, WADDR=BASE_ADDR, WDATA=0, HOLD=1, DONE=0, ERR=0, and the checksum, word and byte counters at 0.
REQ-020 Reset mid-load SHALL abandon the load; the next START SHALL restart at BASE_ADDR.
REQ-021 Release of RST SHALL take effect on the next rising CLK; no output toggles before it.

Verification
REQ-022 START; bytes 01,12,34,56,78,08 SHALL produce one WE pulse with WADDR=00 and WDATA=12345678, then DONE=1, ERR=0, HOLD=0.
REQ-023 START; count 02; 8 data bytes with random IN_VALID gaps; correct checksum SHALL produce WE pulses at WADDR 00 then 04 with correct data and no extra strobes; the IN_READY=0 cycle SHALL equal the WRITE cycle.
REQ-024 START; count 01; 12 34 56 78; checksum FF SHALL still write 12345678 at 00, then DONE=1, ERR=1, HOLD=1.
REQ-025 START; count 00; 256 data bytes SHALL produce 64 writes, the last at WADDR=FC, with the internal address wrapping to 00 and DONE=1.
REQ-026 START; count 41 SHALL produce no WE, then DONE=1, ERR=1; a START during ASSEMBLE SHALL be ignored.
REQ-027 RST=0 asserted after 2 data bytes SHALL force the reset values of REQ-019 at once; a new full load afterwards SHALL write from WADDR=00 with no stale bytes.
